// File: rtl/phase_sequencer_pkg.sv
// ============================================================================
// Module      : phase_sequencer_pkg
// Description : Phase encoding and sequencer state type shared by the
//               sequencer and the datapath phase-decode muxes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package phase_sequencer_pkg;

    localparam logic [2:0] c_PH_P0 = 3'd0;
    localparam logic [2:0] c_PH_P1 = 3'd1;
    localparam logic [2:0] c_PH_P2 = 3'd2;
    localparam logic [2:0] c_PH_P3 = 3'd3;
    localparam logic [2:0] c_PH_P4 = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_P0   = 3'd1,
        ST_P1   = 3'd2,
        ST_P2   = 3'd3,
        ST_P3   = 3'd4,
        ST_P4   = 3'd5,
        ST_HALT = 3'd6
    } state_t;

    // IDLE and HALT both report phase 0
    function automatic logic [2:0] phase_of(input state_t s);
        case (s)
            ST_P0:   return c_PH_P0;
            ST_P1:   return c_PH_P1;
            ST_P2:   return c_PH_P2;
            ST_P3:   return c_PH_P3;
            ST_P4:   return c_PH_P4;
            default: return c_PH_P0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/phase_sequencer_instr_latch.sv
// ============================================================================
// Module      : instr_latch
// Description : Enabled instruction register with asynchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_latch #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/phase_sequencer.sv
// ============================================================================
// Module      : phase_sequencer
// Description : Five-phase instruction sequencer owning the shared RAM port,
//               with run / single-step / halt control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    input  logic              is_hlt,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [DATA_W-1:0] ram_out,
    output logic [2:0]        phase,
    output logic              busy,
    output logic              addr_sel,
    output logic              ram_we,
    output logic [DATA_W-1:0] past_instr,
    output logic              ir_we,
    output logic              rf_we,
    output logic              pc_we,
    output logic              halted,
    output logic [15:0]       instr_count
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_is_step;
    logic        r_halt_pending;
    logic        r_halted;
    logic [15:0] r_instr_count;
    logic        w_start;
    logic        w_unused;

    // A load needs no strobe of its own: selecting the data address in P3 starts the read
    assign w_unused = is_load;

    assign w_start = (r_state == ST_IDLE) && (run || step) && !r_halted;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_nxt = ST_P0;
            ST_P0:   w_state_nxt = ST_P1;
            ST_P1:   w_state_nxt = ST_P2;
            ST_P2:   w_state_nxt = ST_P3;
            ST_P3:   w_state_nxt = ST_P4;
            ST_P4: begin
                if (r_halt_pending)         w_state_nxt = ST_HALT;
                else if (run && !r_is_step) w_state_nxt = ST_P0;
                else                        w_state_nxt = ST_IDLE;
            end
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Per-instruction bookkeeping; a step with run also high counts as run
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is_step      <= 1'b0;
            r_halt_pending <= 1'b0;
            r_halted       <= 1'b0;
            r_instr_count  <= 16'd0;
        end else begin
            if (w_start) begin
                r_is_step      <= step && !run;
                r_halt_pending <= 1'b0;
            end
            if (r_state == ST_P2 && is_hlt) begin
                r_halt_pending <= 1'b1;
            end
            if (r_state == ST_P4) begin
                r_instr_count <= r_instr_count + 16'd1;
                if (r_halt_pending) begin
                    r_halted <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        phase    = phase_of(r_state);
        busy     = 1'b0;
        addr_sel = 1'b0;
        ram_we   = 1'b0;
        ir_we    = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        case (r_state)
            ST_P0: busy = 1'b1;
            ST_P1: begin
                busy  = 1'b1;
                ir_we = 1'b1;
            end
            ST_P2: busy = 1'b1;
            ST_P3: begin
                busy     = 1'b1;
                addr_sel = 1'b1;
                ram_we   = is_store;
            end
            ST_P4: begin
                busy  = 1'b1;
                rf_we = !is_store && !is_hlt;
                pc_we = 1'b1;
            end
            default: ;
        endcase
    end

    instr_latch #(
        .DATA_W (DATA_W)
    ) u_instr_latch (
        .clk  (clk),
        .rst  (reset),
        .i_en (ir_we),
        .i_d  (ram_out),
        .o_q  (past_instr)
    );

    assign halted      = r_halted;
    assign instr_count = r_instr_count;

endmodule

`default_nettype wire

// File: tb/tb_phase_sequencer.sv
// ============================================================================
// Module      : tb_phase_sequencer
// Description : Randomized self-checking bench for phase_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_phase_sequencer;

    localparam logic [7:0] c_DADDR = 8'hF0;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        step;
    logic        is_hlt;
    logic        is_load;
    logic        is_store;
    logic [15:0] ram_out;
    logic [2:0]  phase;
    logic        busy;
    logic        addr_sel;
    logic        ram_we;
    logic [15:0] past_instr;
    logic        ir_we;
    logic        rf_we;
    logic        pc_we;
    logic        halted;
    logic [15:0] instr_count;

    logic [15:0] mem [0:255];
    logic [7:0]  pc;
    logic [8:0]  obs_vec;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_count;
    logic        exp_halted;

    phase_sequencer #(.DATA_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .step        (step),
        .is_hlt      (is_hlt),
        .is_load     (is_load),
        .is_store    (is_store),
        .ram_out     (ram_out),
        .phase       (phase),
        .busy        (busy),
        .addr_sel    (addr_sel),
        .ram_we      (ram_we),
        .past_instr  (past_instr),
        .ir_we       (ir_we),
        .rf_we       (rf_we),
        .pc_we       (pc_we),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    // Registered-read RAM and program counter around the sequencer
    always @(posedge clk) ram_out <= mem[addr_sel ? c_DADDR : pc];

    always @(posedge clk or posedge reset) begin
        if (reset) pc <= 8'd0;
        else if (pc_we) pc <= pc + 8'd1;
    end

    assign obs_vec = {busy, phase, addr_sel, ram_we, ir_we, rf_we, pc_we};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Expected {busy,phase,addr_sel,ram_we,ir_we,rf_we,pc_we} in cycle k of an instruction
    function automatic logic [8:0] exp_vec(input int k, input bit st, input bit hlt);
        if (k < 0) return 9'd0;
        return {1'b1, 3'(k), (k == 3), (k == 3) && st, (k == 1),
                (k == 4) && !st && !hlt, (k == 4)};
    endfunction

    task automatic check_idle();
        check("idle_vec", {23'd0, obs_vec}, {23'd0, exp_vec(-1, 1'b0, 1'b0)});
        check("count", {16'd0, instr_count}, {16'd0, exp_count});
        check("halted", {31'd0, halted}, {31'd0, exp_halted});
    endtask

    task automatic do_step(input logic [15:0] word, input bit ld, input bit st, input bit hlt,
                           input logic [15:0] ldata, input bit restep);
        mem[pc]      = word;
        mem[c_DADDR] = ldata;
        is_load  = ld;
        is_store = st;
        is_hlt   = hlt;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            if (restep) step = (k == 2);
            check("step_vec", {23'd0, obs_vec}, {23'd0, exp_vec(k, st, hlt)});
            if (k == 4) begin
                check("ir_hold", {16'd0, past_instr}, {16'd0, word});
                if (ld) check("load_data", {16'd0, ram_out}, {16'd0, ldata});
            end
        end
        exp_count = exp_count + 16'd1;
        if (hlt) exp_halted = 1'b1;
        @(negedge clk);
        is_load  = 1'b0;
        is_store = 1'b0;
        is_hlt   = 1'b0;
        check_idle();
    endtask

    initial begin
        logic [15:0] w [3];
        logic [7:0]  base;
        int          kind;

        for (int i = 0; i < 256; i++) mem[i] = 16'd0;
        reset = 1'b1; run = 1'b0; step = 1'b0;
        is_hlt = 1'b0; is_load = 1'b0; is_store = 1'b0;
        exp_count = 16'd0; exp_halted = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_vec", {23'd0, obs_vec}, 32'd0);
        check("rst_ir", {16'd0, past_instr}, 32'd0);
        check_idle();
        reset = 1'b0;
        @(negedge clk);

        // Basic step, with a second step pulse while busy that must be ignored
        do_step(16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        do_step(16'h8A01, 1'b1, 1'b0, 1'b0, 16'h00FF, 1'b0);
        do_step(16'h9C02, 1'b0, 1'b1, 1'b0, 16'h5555, 1'b0);

        for (int n = 0; n < 20; n++) begin
            kind = int'($urandom_range(0, 2));
            do_step(16'($urandom), kind == 1, kind == 2, 1'b0, 16'($urandom), 1'($urandom));
        end

        // Three back-to-back instructions under run; run dropped mid third
        base = pc;
        for (int i = 0; i < 3; i++) begin
            w[i] = 16'($urandom);
            mem[base + 8'(i)] = w[i];
        end
        run = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 15; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 12) run = 1'b0;
            check("run_vec", {23'd0, obs_vec}, {23'd0, exp_vec(k % 5, 1'b0, 1'b0)});
            if (k % 5 == 4) check("run_ir", {16'd0, past_instr}, {16'd0, w[k / 5]});
        end
        exp_count = exp_count + 16'd3;
        @(negedge clk);
        check_idle();

        // Reset during P3 of a store clears everything at once
        mem[pc] = 16'hC3C3;
        is_store = 1'b1;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (3) @(negedge clk);
        check("p3_store", {23'd0, obs_vec}, {23'd0, exp_vec(3, 1'b1, 1'b0)});
        reset = 1'b1;
        #1;
        exp_count = 16'd0;
        check("arst_vec", {23'd0, obs_vec}, 32'd0);
        check("arst_ir", {16'd0, past_instr}, 32'd0);
        check_idle();
        @(negedge clk);
        reset = 1'b0;
        is_store = 1'b0;
        @(negedge clk);

        // Counter wrap from 0xFFFF
        force dut.r_instr_count = 16'hFFFF;
        #1;
        release dut.r_instr_count;
        check("preload", {16'd0, instr_count}, 32'h0000FFFF);
        exp_count = 16'hFFFF;
        do_step(16'h4321, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

        // HLT under run completes, then nothing restarts it
        mem[pc] = 16'hF000;
        is_hlt = 1'b1;
        run = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("hlt_vec", {23'd0, obs_vec}, {23'd0, exp_vec(k, 1'b0, 1'b1)});
        end
        exp_count  = exp_count + 16'd1;
        exp_halted = 1'b1;
        @(negedge clk);
        is_hlt = 1'b0;
        check_idle();
        repeat (4) begin
            @(negedge clk);
            check("hlt_run", {23'd0, obs_vec}, 32'd0);
        end
        run  = 1'b0;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("hlt_step", {23'd0, obs_vec}, 32'd0);
        end
        check_idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_count  = 16'd0;
        exp_halted = 1'b0;
        check_idle();
        do_step(16'h0ABC, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/phase_sequencer.md
# phase_sequencer

Multi-cycle phase controller for the 16-bit processor core. It owns the single-port instruction/data RAM and sequences each instruction through five phases: fetch, decode, execute, memory, writeback. It time-shares the RAM between instruction fetch and load/store access, holds the fetched instruction while the RAM output carries load data, and handles run, step and halt control. It sits between the front-panel/run controls, the decoder and the datapath enables.

## Interface
- DATA_W, 16, instruction/data word width
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces idle state
- run  in  1  level; while high and idle, the sequencer starts and keeps issuing instructions
- step  in  1  single-cycle pulse; when idle, executes exactly one instruction
- is_hlt  in  1  decoder flag for the current instruction; sampled in P2
- is_load  in  1  decoder flag, lw; sampled in P3
- is_store  in  1  decoder flag, sw; sampled in P3
- ram_out  in  DATA_W  RAM read data (registered read, valid one cycle after the address)
- phase  out  3  current phase, binary: P0=0 … P4=4; 0 when idle
- busy  out  1  high while an instruction is in flight
- addr_sel  out  1  RAM address mux: 0=PC, 1=ALU data address
- ram_we  out  1  RAM write enable
- past_instr  out  DATA_W  latched instruction word
- ir_we  out  1  instruction latch strobe
- rf_we  out  1  register-file write strobe
- pc_we  out  1  PC update strobe
- halted  out  1  sticky; set by an executed HLT
- instr_count  out  16  retired-instruction counter

## Operation
- States: IDLE, P0…P4, HALT. Reset value of every output is 0, state IDLE.
- IDLE: goes to P0 on run=1 or step=1 (step latched as one-shot). Ignored while halted=1.
- P0 fetch: addr_sel=0, ram read of PC.
- P1 decode: ram_out holds the instruction; ir_we=1; past_instr <= ram_out at the end of P1.
- P2 execute: is_hlt sampled; if set, halt_pending is recorded. No RAM access.
- P3 memory: addr_sel=1; ram_we = is_store. is_load only starts the read.
- P4 writeback: load data is on ram_out; past_instr stays unchanged so the IR path still sees the instruction. rf_we = not is_store and not is_hlt. pc_we=1. instr_count increments and wraps from 0xFFFF to 0.
- After P4, the next state is chosen as follows:
  - HALT if halt_pending; halted is set at this point.
  - P0 if run=1 and this instruction was not a step.
  - IDLE otherwise.
- HALT: busy=0, phase=0. Only reset exits HALT.
- Dropping run mid-instruction does not abort the instruction. It completes through P4, then the sequencer enters IDLE.
- step while busy is ignored, not queued.
- run and step high together in IDLE: treated as run.
- ram_we is asserted only in P3 and only for is_store. It is never asserted in any other state.

## Timing
- Fixed 5 cycles per instruction, no stalls. The first P0 is the cycle after the run/step sample in IDLE.
- Strobes (ir_we, rf_we, pc_we, ram_we) are registered/Moore outputs decoded from state. Each is one cycle wide.
- past_instr updates on the P1→P2 edge.
- instr_count and halted update on the P4 exit edge.
- Back-to-back instructions under run: P4 is followed directly by P0, with no idle gap.
- Reset mid-instruction clears state and all outputs immediately (asynchronous). This includes past_instr and instr_count. No write strobe may glitch during reset.

## Structure
- Shared package: the phase encoding constants P0…P4 and the state enum, because the datapath muxes decode phase.
- One sub-module, instr_latch, holds the DATA_W register for past_instr with an enable and asynchronous clear.
- The FSM, strobe decode and counter stay in phase_sequencer.

## Test plan
- Reset, then step pulse with RAM word 0x1234 at PC: phase sequence is 0,1,2,3,4, then IDLE. past_instr=0x1234, pc_we high in P4 only, instr_count=1, busy drops after P4.
- run held high for 3 instructions: 15 consecutive busy cycles with no gap, instr_count=3.
- Store instruction: ram_we=1 only in P3 with addr_sel=1, and rf_we=0 in P4.
- Load instruction with instruction 0x8A01 and load data 0x00FF: in P4, ram_out=0x00FF while past_instr remains 0x8A01, and rf_we=1.
- HLT under run: the instruction completes P4, then halted=1, busy=0, phase=0. Further run/step has no effect until reset.
- Assert reset during P3 of a store: ram_we and all outputs drop to 0 immediately and state is IDLE. Preloading instr_count to 0xFFFF and retiring one instruction wraps it to 0.
